// File: rtl/icache_pkg.sv
//==============================================================================
// Module      : icache_pkg
// Description : Shared geometry defaults, FSM state type and address helpers
//               for the direct-mapped instruction cache.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef ICACHE_INDEX_WIDTH
`define ICACHE_INDEX_WIDTH 4
`endif
`ifndef ICACHE_OFFSET_WIDTH
`define ICACHE_OFFSET_WIDTH 2
`endif

package icache_pkg;

    localparam int ICACHE_DEF_INDEX_WIDTH  = `ICACHE_INDEX_WIDTH;
    localparam int ICACHE_DEF_OFFSET_WIDTH = `ICACHE_OFFSET_WIDTH;
    localparam int ADDR_WIDTH              = 32;
    localparam int WORD_WIDTH              = 32;
    localparam int BYTE_OFFSET_WIDTH       = 2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } icache_state_e;

    function automatic int tag_width(input int index_width, input int offset_width);
        return ADDR_WIDTH - BYTE_OFFSET_WIDTH - offset_width - index_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/icache_array.sv
//==============================================================================
// Module      : icache_array
// Description : Tag/valid and data storage for the instruction cache; one
//               combinational read port and one synchronous write port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_WIDTH  = ICACHE_DEF_INDEX_WIDTH,
    parameter int OFFSET_WIDTH = ICACHE_DEF_OFFSET_WIDTH,
    parameter int TAG_WIDTH    = tag_width(ICACHE_DEF_INDEX_WIDTH, ICACHE_DEF_OFFSET_WIDTH)
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [INDEX_WIDTH-1:0]  rd_index,
    input  logic [OFFSET_WIDTH-1:0] rd_offset,
    output logic                    rd_valid,
    output logic [TAG_WIDTH-1:0]    rd_tag,
    output logic [WORD_WIDTH-1:0]   rd_data,
    input  logic                    wr_data_en,
    input  logic [INDEX_WIDTH-1:0]  wr_index,
    input  logic [OFFSET_WIDTH-1:0] wr_offset,
    input  logic [WORD_WIDTH-1:0]   wr_data,
    input  logic                    wr_tag_en,
    input  logic [TAG_WIDTH-1:0]    wr_tag
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int WORDS = 1 << (INDEX_WIDTH + OFFSET_WIDTH);

    logic [TAG_WIDTH-1:0]  tag_mem  [LINES];
    logic [WORD_WIDTH-1:0] data_mem [WORDS];
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      valid_d;

    always_comb begin
        valid_d = valid_q;
        if (wr_tag_en) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    // Only the valid bits need clearing; stale tags/data are masked by them.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_data_en) begin
            data_mem[{wr_index, wr_offset}] <= wr_data;
        end
        if (wr_tag_en) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

`default_nettype wire

// File: rtl/icache.sv
//==============================================================================
// Module      : icache
// Description : Direct-mapped read-only instruction cache; 1-cycle hits,
//               whole-line sequential refill from the memory controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module icache
    import icache_pkg::*;
#(
    parameter int INDEX_WIDTH  = ICACHE_DEF_INDEX_WIDTH,
    parameter int OFFSET_WIDTH = ICACHE_DEF_OFFSET_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  fe_en,
    input  logic [ADDR_WIDTH-1:0] fe_addr,
    output logic                  fe_rdy,
    output logic [WORD_WIDTH-1:0] fe_data,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rdy,
    input  logic [WORD_WIDTH-1:0] mem_data
);

    localparam int TAG_WIDTH = tag_width(INDEX_WIDTH, OFFSET_WIDTH);
    localparam int WADDR_WIDTH = ADDR_WIDTH - BYTE_OFFSET_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = '1;

    icache_state_e             state_q,      state_d;
    logic [OFFSET_WIDTH-1:0]   counter_q,    counter_d;
    logic [TAG_WIDTH-1:0]      tag_q,        tag_d;
    logic [INDEX_WIDTH-1:0]    index_q,      index_d;
    logic                      mem_en_q,     mem_en_d;
    logic [ADDR_WIDTH-1:0]     mem_addr_q,   mem_addr_d;
    logic                      resp_valid_q, resp_valid_d;
    logic [WADDR_WIDTH-1:0]    resp_addr_q,  resp_addr_d;
    logic [WORD_WIDTH-1:0]     resp_data_q,  resp_data_d;

    logic [TAG_WIDTH-1:0]      fe_tag;
    logic [INDEX_WIDTH-1:0]    fe_index;
    logic [OFFSET_WIDTH-1:0]   fe_offset;
    logic                      rd_valid;
    logic [TAG_WIDTH-1:0]      rd_tag;
    logic [WORD_WIDTH-1:0]     rd_data;
    logic                      lookup_hit;
    logic                      wr_data_en;
    logic                      wr_tag_en;
    logic                      unused_byte_bits;

    assign fe_offset        = fe_addr[BYTE_OFFSET_WIDTH +: OFFSET_WIDTH];
    assign fe_index         = fe_addr[BYTE_OFFSET_WIDTH + OFFSET_WIDTH +: INDEX_WIDTH];
    assign fe_tag           = fe_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign unused_byte_bits = ^fe_addr[BYTE_OFFSET_WIDTH-1:0];

    icache_array #(
        .INDEX_WIDTH  (INDEX_WIDTH),
        .OFFSET_WIDTH (OFFSET_WIDTH),
        .TAG_WIDTH    (TAG_WIDTH)
    ) u_array (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .rd_index   (fe_index),
        .rd_offset  (fe_offset),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_data_en (wr_data_en),
        .wr_index   (index_q),
        .wr_offset  (counter_q),
        .wr_data    (mem_data),
        .wr_tag_en  (wr_tag_en),
        .wr_tag     (tag_q)
    );

    assign lookup_hit = rd_valid && (rd_tag == fe_tag);

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        tag_d        = tag_q;
        index_d      = index_q;
        mem_en_d     = mem_en_q;
        mem_addr_d   = mem_addr_q;
        resp_valid_d = resp_valid_q;
        resp_addr_d  = resp_addr_q;
        resp_data_d  = resp_data_q;
        wr_data_en   = 1'b0;
        wr_tag_en    = 1'b0;

        if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    resp_valid_d = 1'b0;
                    if (fe_en) begin
                        if (lookup_hit) begin
                            resp_valid_d = 1'b1;
                            resp_addr_d  = fe_addr[ADDR_WIDTH-1:BYTE_OFFSET_WIDTH];
                            resp_data_d  = rd_data;
                        end else begin
                            tag_d     = fe_tag;
                            index_d   = fe_index;
                            counter_d = '0;
                            state_d   = ST_REFILL;
                        end
                    end
                end
                ST_REFILL: begin
                    // Every word is preceded by one idle cycle with mem_en low.
                    if (!mem_en_q) begin
                        mem_en_d   = 1'b1;
                        mem_addr_d = {tag_q, index_q, counter_q, {BYTE_OFFSET_WIDTH{1'b0}}};
                    end else if (mem_rdy) begin
                        wr_data_en = 1'b1;
                        mem_en_d   = 1'b0;
                        counter_d  = counter_q + 1'b1;
                        if (counter_q == LAST_WORD) begin
                            wr_tag_en = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            counter_q    <= '0;
            tag_q        <= '0;
            index_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            resp_valid_q <= resp_valid_d;
            resp_addr_q  <= resp_addr_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Gating with the live request drops any response whose fetch has moved on.
    assign fe_rdy   = resp_valid_q && fe_en &&
                      (fe_addr[ADDR_WIDTH-1:BYTE_OFFSET_WIDTH] == resp_addr_q);
    assign fe_data  = resp_data_q;
    assign mem_en   = mem_en_q;
    assign mem_addr = mem_addr_q;

endmodule

`default_nettype wire
